// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide with stall request.
// Define MULDIV_FAST_MUL_EN to compute MUL* in a single cycle; the divide path is unchanged.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start_i,
    input  logic [2:0]      Funct3_i,
    input  logic [XLEN-1:0] SrcAE_i,
    input  logic [XLEN-1:0] SrcBE_i,
    input  logic            Kill_i,
    output logic            StallReq_o,
    output logic            Done_o,
    output logic [XLEN-1:0] Result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode for the accept cycle
    logic            is_div, is_sdiv, sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div      = Funct3_i[2];
        is_sdiv     = is_div & ~Funct3_i[0];
        sign_a      = (Funct3_i == 3'd1) | (Funct3_i == 3'd2) | is_sdiv;
        sign_b      = (Funct3_i == 3'd1) | is_sdiv;
        a_neg       = sign_a & SrcAE_i[XLEN-1];
        b_neg       = sign_b & SrcBE_i[XLEN-1];
        a_mag       = a_neg ? -SrcAE_i : SrcAE_i;
        b_mag       = b_neg ? -SrcBE_i : SrcBE_i;
        div_zero    = is_div & (SrcBE_i == '0);
        div_ovf     = is_sdiv & (SrcAE_i == MIN_NEG) & (SrcBE_i == '1);
        special     = div_zero | div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = Funct3_i[1] ? SrcAE_i : '1;
        end else if (div_ovf) begin
            special_res = Funct3_i[1] ? '0 : MIN_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
        fast_res  = (Funct3_i[1:0] == 2'd0) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`endif

    // One iteration of the datapath; the partial remainder is widened to 33 bits
    // so a remainder with its MSB set still compares correctly after the shift.
    logic [2*XLEN-1:0] shifted, div_step, mul_step, step, prod_fix;
    logic [XLEN+1:0]   diff;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        shifted  = {acc_q[2*XLEN-2:0], 1'b0};
        diff     = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
        div_step = diff[XLEN+1] ? shifted : {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_step = {sum, acc_q[XLEN-1:1]};
        step     = op_q[2] ? div_step : mul_step;
        quo      = negq_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem      = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        prod_fix = negq_q ? -step : step;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    op_d   = Funct3_i;
                    opb_d  = b_mag;
                    acc_d  = {{XLEN{1'b0}}, a_mag};
                    cnt_d  = '0;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_d = fast_res;
                        state_d  = DONE;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over everything and leaves the last result visible
        if (Kill_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign StallReq_o = (((state_q == IDLE) & Start_i) | (state_q == CALC)) & ~Kill_i;
    assign Done_o     = (state_q == DONE);
    assign Result_o   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed RV32M ops against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start_i;
    logic [2:0]  Funct3_i;
    logic [31:0] SrcAE_i;
    logic [31:0] SrcBE_i;
    logic        Kill_i;
    logic        StallReq_o;
    logic        Done_o;
    logic [31:0] Result_o;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start_i    (Start_i),
        .Funct3_i   (Funct3_i),
        .SrcAE_i    (SrcAE_i),
        .SrcBE_i    (SrcBE_i),
        .Kill_i     (Kill_i),
        .StallReq_o (StallReq_o),
        .Done_o     (Done_o),
        .Result_o   (Result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          issue_cyc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [31:0] last_result = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'h0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    // Monitor: every Done_o pops one expectation
    always @(negedge clk) begin
        if (rst_n && Done_o) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: got Done_o=1 with no op pending, required 0");
            end else begin
                mon_e = sb_q.pop_front();
                check("result", Result_o, mon_e.res);
                check("latency", 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
                $display("op f3=%0d a=%h b=%h -> %h (exp %h) lat=%0d",
                         mon_e.f3, mon_e.a, mon_e.b, Result_o, mon_e.res, cyc - mon_e.issue_cyc);
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit wait_first);
        exp_t e;
        int   stalls;
        bit   seen;
        if (wait_first) @(negedge clk);
        e.f3 = f3; e.a = a; e.b = b;
        e.res = ref_model(f3, a, b);
        e.lat = ref_lat(f3, a, b);
        e.issue_cyc = cyc;
        sb_q.push_back(e);
        Funct3_i = f3; SrcAE_i = a; SrcBE_i = b; Start_i = 1'b1;
        stalls = 0;
        seen = 1'b0;
        #1 if (StallReq_o) stalls++;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            Start_i = 1'b0;
            if (Done_o) begin
                seen = 1'b1;
                break;
            end
            #1 if (StallReq_o) stalls++;
        end
        if (!seen) begin
            chk_cnt++;
            $display("FAIL done_timeout: got no Done_o in 100 cycles, required one");
        end
        check("stall_cycles", 32'(stalls), 32'(e.lat));
        last_result = e.res;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1 ms, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; Start_i = 1'b0; Kill_i = 1'b0;
        Funct3_i = 3'd0; SrcAE_i = 32'h0; SrcBE_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", {31'h0, StallReq_o}, 32'h0);
        check("reset_done", {31'h0, Done_o}, 32'h0);
        check("reset_result", Result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd5, 32'd100, 32'd7, 1'b1);
        run_op(3'd7, 32'd100, 32'd7, 1'b1);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 1'b1);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 1'b1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd5, 32'd5, 32'd0, 1'b1);
        run_op(3'd7, 32'd5, 32'd0, 1'b1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Kill in CALC cycle 10, then a fresh op on the following cycle
        @(negedge clk);
        Funct3_i = 3'd5; SrcAE_i = 32'd1000; SrcBE_i = 32'd3; Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        repeat (9) @(negedge clk);
        Kill_i = 1'b1;
        #1 check("kill_stall", {31'h0, StallReq_o}, 32'h0);
        @(negedge clk);
        Kill_i = 1'b0;
        check("kill_done", {31'h0, Done_o}, 32'h0);
        check("kill_result_hold", Result_o, last_result);
        run_op(3'd5, 32'd9, 32'd3, 1'b0);

        // Reset in CALC cycle 20
        @(negedge clk);
        Funct3_i = 3'd5; SrcAE_i = 32'd12345; SrcBE_i = 32'd11; Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_stall", {31'h0, StallReq_o}, 32'h0);
        check("midreset_done", {31'h0, Done_o}, 32'h0);
        check("midreset_result", Result_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 1'b0);
        run_op(3'd0, 32'd12345, 32'd6789, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
